// File: rtl/irq_sequencer.sv
// Multi-source interrupt controller: latches request edges, picks the lowest-index
// enabled source and steps the pipeline through flush / push PC / push flags / load vector.
module irq_sequencer #(
  parameter int NUM_SRC      = 4,
  parameter int FLUSH_CYCLES = 3,
  parameter int ADDR_W       = 16,
  parameter int VEC_BASE     = 0,
  parameter int VEC_STRIDE   = 2,
  parameter int IDX_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               gie,
  input  logic               stall,
  input  logic               rti,
  output logic [3:0]         ctrl_code,
  output logic [IDX_W-1:0]   vector_id,
  output logic [ADDR_W-1:0]  vec_addr,
  output logic [NUM_SRC-1:0] ack,
  output logic               busy,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [3:0] CODE_NONE  = 4'b0000;
  localparam logic [3:0] CODE_FLUSH = 4'b0001;
  localparam logic [3:0] CODE_PC    = 4'b0011;
  localparam logic [3:0] CODE_FLAGS = 4'b0111;
  localparam logic [3:0] CODE_VEC   = 4'b1000;

  typedef enum logic [2:0] {
    IDLE, FLUSH, PUSH_PC, PUSH_FLAGS, LOAD_VEC, SERVICE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [31:0]        win_addr;
  logic               accept;

  assign rise   = irq_in & ~irq_prev;
  assign cand   = pending & irq_mask;
  // Isolate the lowest set bit: index 0 has the highest priority.
  assign win_oh = cand & (~cand + NUM_SRC'(1));
  assign accept = (state == IDLE) && gie && !stall && (|cand);

  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDX_W'(i);
    end
  end

  assign win_addr = 32'(VEC_BASE) + 32'(win_idx) * 32'(VEC_STRIDE);

  // ack is a one-cycle pulse with no ready: the source sees it exactly once per accept
  // and must not expect it to be held; a new edge during that cycle re-pends the source.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      irq_prev   <= irq_in;
      pending    <= '0;
      ctrl_code  <= CODE_NONE;
      vector_id  <= '0;
      vec_addr   <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      in_service <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      ack      <= '0;
      pending  <= (pending & ~(accept ? win_oh : '0)) | rise;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= FLUSH;
            cnt        <= '0;
            ctrl_code  <= CODE_FLUSH;
            vector_id  <= win_idx;
            vec_addr   <= ADDR_W'(win_addr);
            ack        <= win_oh;
            busy       <= 1'b1;
            in_service <= 1'b1;
          end
        end
        FLUSH: begin
          if (!stall) begin
            if (cnt == CNT_LAST) begin
              state     <= PUSH_PC;
              ctrl_code <= CODE_PC;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        PUSH_PC: begin
          if (!stall) begin
            state     <= PUSH_FLAGS;
            ctrl_code <= CODE_FLAGS;
          end
        end
        PUSH_FLAGS: begin
          if (!stall) begin
            state     <= LOAD_VEC;
            ctrl_code <= CODE_VEC;
          end
        end
        LOAD_VEC: begin
          if (!stall) begin
            state     <= SERVICE;
            ctrl_code <= CODE_NONE;
            busy      <= 1'b0;
          end
        end
        SERVICE: begin
          if (rti) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ctrl_code <= CODE_NONE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: a schedule-queue model checked every cycle, plus directed
// vectors with literal expectations taken from the intended behaviour.
module tb_irq_sequencer;

  localparam int NUM_SRC      = 4;
  localparam int FLUSH_CYCLES = 3;
  localparam int ADDR_W       = 16;
  localparam int VEC_BASE     = 0;
  localparam int VEC_STRIDE   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  irq_in, irq_mask;
  logic        gie, stall, rti;
  logic [3:0]  ctrl_code;
  logic [1:0]  vector_id;
  logic [15:0] vec_addr;
  logic [3:0]  ack;
  logic        busy, in_service;
  logic [3:0]  pending;

  logic [0:0]  irq1, mask1, ack1, pending1, vector_id1;
  logic        rti1, busy1, in_service1;
  logic [3:0]  ctrl_code1;
  logic [15:0] vec_addr1;

  irq_sequencer #(.NUM_SRC(NUM_SRC), .FLUSH_CYCLES(FLUSH_CYCLES), .ADDR_W(ADDR_W),
                  .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .gie(gie),
    .stall(stall), .rti(rti), .ctrl_code(ctrl_code), .vector_id(vector_id),
    .vec_addr(vec_addr), .ack(ack), .busy(busy), .in_service(in_service),
    .pending(pending)
  );

  irq_sequencer #(.NUM_SRC(1)) dut1 (
    .clk(clk), .rst(rst), .irq_in(irq1), .irq_mask(mask1), .gie(gie),
    .stall(stall), .rti(rti1), .ctrl_code(ctrl_code1), .vector_id(vector_id1),
    .vec_addr(vec_addr1), .ack(ack1), .busy(busy1), .in_service(in_service1),
    .pending(pending1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Idle is simply "not in service"; the entry sequence is a queue of codes still to show.
  logic [3:0]  m_pending, m_prev, m_ack, m_code;
  logic [1:0]  m_vid;
  logic [15:0] m_addr;
  logic        m_busy, m_insvc;
  logic [3:0]  exp_q[$];

  task automatic model_step();
    logic [3:0] rise, cand, clr;
    int w;
    logic acc;
    if (rst) begin
      m_pending = '0; m_prev = irq_in; m_ack = '0; m_code = '0;
      m_vid = '0; m_addr = '0; m_busy = 1'b0; m_insvc = 1'b0;
      exp_q.delete();
      return;
    end
    rise   = irq_in & ~m_prev;
    m_prev = irq_in;
    cand   = m_pending & irq_mask;
    w = -1;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (cand[i]) w = i;
    acc   = !m_insvc && gie && !stall && (w >= 0);
    m_ack = '0;
    clr   = '0;
    if (m_busy) begin
      if (!stall) begin
        if (exp_q.size() > 0) m_code = exp_q.pop_front();
        else begin m_code = 4'b0000; m_busy = 1'b0; end
      end
    end else if (m_insvc && rti) begin
      m_insvc = 1'b0;
    end
    if (acc) begin
      clr[w] = 1'b1;
      m_ack  = clr;
      m_vid  = 2'(w);
      m_addr = 16'(VEC_BASE + w * VEC_STRIDE);
      m_code = 4'b0001;
      m_busy = 1'b1;
      m_insvc = 1'b1;
      exp_q.delete();
      for (int i = 1; i < FLUSH_CYCLES; i++) exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0111);
      exp_q.push_back(4'b1000);
    end
    m_pending = (m_pending & ~clr) | rise;
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  always @(posedge clk) begin
    model_step();
    #1;
    chk("ctrl_code", 32'(ctrl_code), 32'(m_code));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("in_service", 32'(in_service), 32'(m_insvc));
    chk("pending", 32'(pending), 32'(m_pending));
    chk("ack", 32'(ack), 32'(m_ack));
    if (m_insvc) begin
      chk("vector_id", 32'(vector_id), 32'(m_vid));
      chk("vec_addr", 32'(vec_addr), 32'(m_addr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rti();
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] seq_codes [7];
  int ones;

  initial begin
    seq_codes = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b0000};
    rst = 1'b1; irq_in = '0; irq_mask = 4'b1111; gie = 1'b1; stall = 1'b0; rti = 1'b0;
    irq1 = 1'b0; mask1 = 1'b1; rti1 = 1'b0;
    cyc(2);
    chk("reset_code", 32'(ctrl_code), 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_insvc", 32'(in_service), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // single request on source 2
    irq_in = 4'b0100;
    @(negedge clk);
    chk("t1_pending", 32'(pending), 32'h4);
    @(negedge clk);
    chk("t1_ack", 32'(ack), 32'h4);
    chk("t1_vid", 32'(vector_id), 32'h2);
    chk("t1_addr", 32'(vec_addr), 32'h0004);
    chk("t1_cleared", 32'(pending), 32'h0);
    chk("t1_code0", 32'(ctrl_code), 32'(seq_codes[0]));
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      chk("t1_code", 32'(ctrl_code), 32'(seq_codes[i]));
      chk("t1_busy", 32'(busy), (i < 6) ? 32'h1 : 32'h0);
    end
    chk("t1_ack_gone", 32'(ack), 32'h0);
    chk("t1_insvc", 32'(in_service), 32'h1);
    pulse_rti();
    chk("t1_rti", 32'(in_service), 32'h0);

    // priority: sources 3 and 1 together, no nesting
    irq_in = 4'b1010;
    @(negedge clk);
    chk("t2_pending", 32'(pending), 32'ha);
    @(negedge clk);
    chk("t2_addr1", 32'(vec_addr), 32'h0002);
    chk("t2_vid1", 32'(vector_id), 32'h1);
    chk("t2_held", 32'(pending), 32'h8);
    cyc(6);
    chk("t2_svc", 32'(in_service), 32'h1);
    chk("t2_nonest", 32'(pending), 32'h8);
    pulse_rti();
    chk("t2_idle_insvc", 32'(in_service), 32'h0);
    chk("t2_idle_ack", 32'(ack), 32'h0);
    @(negedge clk);
    chk("t2_addr3", 32'(vec_addr), 32'h0006);
    chk("t2_ack3", 32'(ack), 32'h8);
    @(negedge clk);
    pulse_rti();
    chk("t2_rti_busy_ignored", 32'(in_service), 32'h1);
    chk("t2_still_busy", 32'(busy), 32'h1);
    cyc(5);
    chk("t2_svc3", 32'(busy), 32'h0);
    pulse_rti();

    // mask and global enable
    irq_in = 4'b0000; irq_mask = 4'b1110;
    @(negedge clk);
    irq_in = 4'b0001;
    cyc(4);
    chk("t3_masked_pending", 32'(pending), 32'h1);
    chk("t3_masked_busy", 32'(busy), 32'h0);
    irq_mask = 4'b1111;
    @(negedge clk);
    chk("t3_unmask_ack", 32'(ack), 32'h1);
    cyc(6);
    pulse_rti();
    gie = 1'b0; irq_in = 4'b0011;
    cyc(4);
    chk("t3_gie_pending", 32'(pending), 32'h2);
    chk("t3_gie_idle", 32'(in_service), 32'h0);

    // stall for two cycles in the second flush cycle
    gie = 1'b1;
    @(negedge clk);
    ones = (ctrl_code == 4'b0001) ? 1 : 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (ctrl_code == 4'b0001) ones++;
      if (c == 1) stall = 1'b1;
      if (c == 3) stall = 1'b0;
    end
    chk("t4_flush_len", 32'(ones), 32'd5);
    chk("t4_svc_code", 32'(ctrl_code), 32'h0);
    stall = 1'b1; rti = 1'b1;
    @(negedge clk);
    stall = 1'b0; rti = 1'b0;
    chk("t4_stall_rti", 32'(in_service), 32'h0);

    // reset in PUSH_FLAGS with request lines held high
    irq_in = 4'b1011;
    @(negedge clk);
    @(negedge clk);
    chk("t5_ack", 32'(ack), 32'h8);
    cyc(4);
    chk("t5_flags", 32'(ctrl_code), 32'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_code", 32'(ctrl_code), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_insvc", 32'(in_service), 32'h0);
    chk("t5_pending", 32'(pending), 32'h0);
    @(negedge clk);
    chk("t5_no_spurious", 32'(pending), 32'h0);

    // re-edge on source 2 in its own accept cycle
    gie = 1'b0; irq_in = 4'b0000;
    @(negedge clk);
    irq_in = 4'b0100;
    @(negedge clk);
    chk("t6_pend", 32'(pending), 32'h4);
    irq_in = 4'b0000;
    @(negedge clk);
    gie = 1'b1; irq_in = 4'b0100;
    @(negedge clk);
    chk("t6_ack", 32'(ack), 32'h4);
    chk("t6_repend", 32'(pending), 32'h4);
    cyc(6);
    pulse_rti();
    @(negedge clk);
    chk("t6_again_ack", 32'(ack), 32'h4);
    chk("t6_again_pend", 32'(pending), 32'h0);
    cyc(6);
    pulse_rti();

    // single-source build
    irq1 = 1'b1;
    @(negedge clk);
    chk("t7_pending1", 32'(pending1), 32'h1);
    @(negedge clk);
    chk("t7_ack1", 32'(ack1), 32'h1);
    chk("t7_vid1", 32'(vector_id1), 32'h0);
    chk("t7_addr1", 32'(vec_addr1), 32'h0);
    chk("t7_code1", 32'(ctrl_code1), 32'h1);
    chk("t7_busy1", 32'(busy1), 32'h1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
